datapath_multi: RTL and testbench
=================================

# datapath_multi

Parametrised successor to the two-register 8-bit datapath: an N-register file, shared internal bus and a registered ALU with add/sub/logic and multi-cycle shift operations. Flags N/Z/C/V are registered, and a busy/done handshake reports ALU completion. It sits between the control unit, which drives the `i_ctrl*` lines, and external bus sources such as memory and the IO override.

## Interface
- `WIDTH`, 8: data width. Power of two, 4..32.
- `REG_COUNT`, 4: register count. Power of two, 2..16.
- Derived: `RSEL_W = $clog2(REG_COUNT)`, `SH_W = $clog2(WIDTH)`.

Ports:
- `i_clk`  in  1  single clock, rising edge.
- `i_reset`  in  1  asynchronous, active-high reset.
- `i_busIn`  in  WIDTH  external bus value.
- `i_busInEn`  in  1  external source drives the bus.
- `i_ctrlRegBusEn`  in  1  register `i_ctrlRegBusSel` drives the bus.
- `i_ctrlRegBusSel`  in  RSEL_W  register selected onto the bus.
- `i_ctrlAluOE`  in  1  ALU result register drives the bus.
- `i_ctrlRegWrEn`  in  1  write the bus value into register `i_ctrlRegWrSel`.
- `i_ctrlRegWrSel`  in  RSEL_W  register write target.
- `i_ctrlAluSelA`  in  RSEL_W  operand A register.
- `i_ctrlAluSelB`  in  RSEL_W  operand B register.
- `i_ctrlAluOp`  in  3  operation: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 ASR.
- `i_ctrlAluStart`  in  1  start an operation.
- `o_bus`  out  WIDTH  resolved bus value.
- `o_busConflict`  out  1  more than one bus source enabled.
- `o_aluResult`  out  WIDTH  result register.
- `o_aluBusy`  out  1  operation in progress.
- `o_aluDone`  out  1  one-cycle pulse on completion.
- `o_aluFlagN`, `o_aluFlagZ`, `o_aluFlagC`, `o_aluFlagV`  out  1 each  registered flags.

## Operation
- **Bus** (combinational):
  - Priority is `i_busIn` > ALU result > register.
  - With no source enabled, `o_bus` = 0.
  - `o_busConflict` = 1 whenever two or more enables are high.
- **Register write:** on a rising edge with `i_ctrlRegWrEn` high, `reg[i_ctrlRegWrSel] <= o_bus`. Writes are allowed while the ALU is busy.
- **ALU state machine** (IDLE, RUN):
  - IDLE plus start: capture `opA = reg[SelA]`, `opB = reg[SelB]` and the op, load `cnt`, go to RUN.
  - `cnt` for ADD/SUB/logic ops = 1.
  - `cnt` for shifts = `opB[SH_W-1:0]`; a value of 0 is loaded as 1 and performs no shift.
  - RUN: each edge decrements `cnt`. Shifts move the working value by one bit per edge.
  - When `cnt` reaches 0: write the result and flags, pulse `o_aluDone`, return to IDLE.
  - Start while in RUN is ignored.
  - Register writes after capture do not affect the running operation.
- **Arithmetic:** all results are modulo 2^WIDTH.
- **Flags:**
  - N = result MSB.
  - Z = (result == 0).
  - ADD: C = carry out; V = signed overflow.
  - SUB (A−B): C = 1 when A ≥ B unsigned (no borrow); V = signed overflow.
  - Logic ops: C = 0, V = 0.
  - Shifts: C = last bit shifted out (0 if no shift performed); V = 0.
  - SHR shifts in 0. ASR replicates the MSB.
- **Reset** (asynchronous, any state):
  - All registers, `o_aluResult` and all flags go to 0.
  - State goes to IDLE, so `o_aluBusy` = 0 and `o_aluDone` = 0.
  - A reset mid-operation discards the operation; no done pulse follows.

## Timing
- Start sampled at edge T0: `o_aluBusy` = 1 from T0 until edge T0+L, where L = `cnt` as loaded.
- Result and flags update at edge T0+L. `o_aluDone` is high for the single cycle after T0+L, concurrent with `o_aluBusy` = 0.
- Back-to-back: a start in the done cycle is accepted at the next edge.
- The result and flags hold until the next completion.
- Operands read the register file at T0. A same-edge register write is not seen.

## Test plan
- **Writes and ADD:** bus 0x2A → r0, then 0x15 → r1, then ADD r0,r1 → after 1 cycle result 0x3F, done pulse, N=0 Z=0 C=0 V=0. With `i_ctrlAluOE` high, `o_bus` = 0x3F.
- **SUB:**
  - r1−r0 → 0xEB, N=1, C=0, V=0.
  - r0−r0 → 0x00, Z=1, C=1.
  - 0x80−0x01 → 0x7F, V=1.
- **ADD overflow:** 0x7F+0x01 → 0x80, N=1, V=1, C=0. 0xFF+0x01 → 0x00, Z=1, C=1.
- **Shifts:**
  - SHL 0x81 by 3 → busy exactly 3 cycles, result 0x08, C=0.
  - ASR 0x80 by 2 → 0xE0, C=0.
  - SHR 0x01 by 1 → 0x00, Z=1, C=1.
  - Shift by 0 → 1 cycle, result = A, C=0.
- **Busy and reset:** start during a SHL by 5 is ignored (the result is that of the first op). Reset at cycle 2 of a SHL by 7 → busy=0, result=0, all registers 0, no done pulse.
- **Bus contention:** `i_busInEn` + `i_ctrlAluOE` + `i_ctrlRegBusEn` together → `o_bus` = `i_busIn`, `o_busConflict` = 1. No enables → `o_bus` = 0, conflict = 0.

Source files
------------

// File: rtl/datapath_multi.sv
// datapath_multi
// -----------------------------------------------------------------------------
// Parametrised datapath: a REG_COUNT-entry register file, one shared internal
// bus, and a registered ALU. Add/sub/logic operations take one cycle. Shifts
// take one cycle per bit position, with a busy/done handshake for completion.
//
// Parameters
//   WIDTH      data width (power of two, 4..32)
//   REG_COUNT  number of registers (power of two, 2..16)
//
// Ports
//   i_clk, i_reset           clock (rising edge), async active-high reset
//   i_busIn, i_busInEn       external bus source (highest priority)
//   i_ctrlRegBusEn/Sel       register placed onto the bus (lowest priority)
//   i_ctrlAluOE              ALU result register placed onto the bus
//   i_ctrlRegWrEn/Sel        write the resolved bus value into a register
//   i_ctrlAluSelA/SelB       operand registers for the next operation
//   i_ctrlAluOp              0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SHL,6 SHR,7 ASR
//   i_ctrlAluStart           start an operation (ignored while busy)
//   o_bus, o_busConflict     resolved bus value, more than one source enabled
//   o_aluResult              result register
//   o_aluBusy, o_aluDone     operation in progress, one-cycle completion pulse
//   o_aluFlagN/Z/C/V         registered flags of the last completed operation
// -----------------------------------------------------------------------------
module datapath_multi #(
  parameter int WIDTH     = 8,
  parameter int REG_COUNT = 4,
  localparam int RSEL_W   = $clog2(REG_COUNT),
  localparam int SH_W     = $clog2(WIDTH)
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [WIDTH-1:0]  i_busIn,
  input  logic              i_busInEn,
  input  logic              i_ctrlRegBusEn,
  input  logic [RSEL_W-1:0] i_ctrlRegBusSel,
  input  logic              i_ctrlAluOE,
  input  logic              i_ctrlRegWrEn,
  input  logic [RSEL_W-1:0] i_ctrlRegWrSel,
  input  logic [RSEL_W-1:0] i_ctrlAluSelA,
  input  logic [RSEL_W-1:0] i_ctrlAluSelB,
  input  logic [2:0]        i_ctrlAluOp,
  input  logic              i_ctrlAluStart,
  output logic [WIDTH-1:0]  o_bus,
  output logic              o_busConflict,
  output logic [WIDTH-1:0]  o_aluResult,
  output logic              o_aluBusy,
  output logic              o_aluDone,
  output logic              o_aluFlagN,
  output logic              o_aluFlagZ,
  output logic              o_aluFlagC,
  output logic              o_aluFlagV
);

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_ASR = 3'd7
  } aluOpT;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } aluStateT;

  // Register file and ALU state
  logic [WIDTH-1:0] regFileQ [REG_COUNT];

  aluStateT         stateQ, stateD;
  logic [WIDTH-1:0] workQ, workD;
  logic [WIDTH-1:0] opBQ, opBD;
  aluOpT            opQ, opD;
  logic [SH_W-1:0]  cntQ, cntD;
  logic             noShiftQ, noShiftD;
  logic [WIDTH-1:0] resultQ, resultD;
  logic             flagNQ, flagND;
  logic             flagZQ, flagZD;
  logic             flagCQ, flagCD;
  logic             flagVQ, flagVD;
  logic             doneQ, doneD;

  // Bus resolution: external input wins, then the ALU result, then a register.
  // Conflict only reports contention; the priority order still picks a value.
  logic [1:0]       enCount;
  logic [WIDTH-1:0] regBusVal;

  always_comb begin
    enCount   = 2'(i_busInEn) + 2'(i_ctrlAluOE) + 2'(i_ctrlRegBusEn);
    regBusVal = regFileQ[i_ctrlRegBusSel];
    o_busConflict = (enCount >= 2'd2);
    if (i_busInEn) begin
      o_bus = i_busIn;
    end else if (i_ctrlAluOE) begin
      o_bus = resultQ;
    end else if (i_ctrlRegBusEn) begin
      o_bus = regBusVal;
    end else begin
      o_bus = '0;
    end
  end

  // Register file write port; writes stay legal while the ALU runs because
  // the running operation works only on its captured operand copies.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regFileQ[i] <= '0;
      end
    end else if (i_ctrlRegWrEn) begin
      regFileQ[i_ctrlRegWrSel] <= o_bus;
    end
  end

  // Operand capture values seen at the start edge (pre-write register contents)
  logic [WIDTH-1:0] capA, capB;
  logic [SH_W-1:0]  capAmt;
  logic             startIsShift;

  always_comb begin
    capA         = regFileQ[i_ctrlAluSelA];
    capB         = regFileQ[i_ctrlAluSelB];
    capAmt       = capB[SH_W-1:0];
    startIsShift = (i_ctrlAluOp == OP_SHL) || (i_ctrlAluOp == OP_SHR) ||
                   (i_ctrlAluOp == OP_ASR);
  end

  // One-bit shift step of the working value and the bit it pushes out.
  logic [WIDTH-1:0] stepVal;
  logic             stepOut;
  logic             opIsShift;

  always_comb begin
    opIsShift = (opQ == OP_SHL) || (opQ == OP_SHR) || (opQ == OP_ASR);
    case (opQ)
      OP_SHL: begin
        stepVal = {workQ[WIDTH-2:0], 1'b0};
        stepOut = workQ[WIDTH-1];
      end
      OP_SHR: begin
        stepVal = {1'b0, workQ[WIDTH-1:1]};
        stepOut = workQ[0];
      end
      OP_ASR: begin
        stepVal = {workQ[WIDTH-1], workQ[WIDTH-1:1]};
        stepOut = workQ[0];
      end
      default: begin
        stepVal = workQ;
        stepOut = 1'b0;
      end
    endcase
  end

  // Final result and carry/overflow of the operation, valid on the last
  // RUN edge. For shifts the last step is applied here; a zero-length shift
  // passes the operand through with carry cleared.
  logic [WIDTH:0]   addFull;
  logic [WIDTH-1:0] subRes;
  logic [WIDTH-1:0] finalRes;
  logic             finalC, finalV;

  always_comb begin
    addFull  = {1'b0, workQ} + {1'b0, opBQ};
    subRes   = workQ - opBQ;
    finalRes = '0;
    finalC   = 1'b0;
    finalV   = 1'b0;
    case (opQ)
      OP_ADD: begin
        finalRes = addFull[WIDTH-1:0];
        finalC   = addFull[WIDTH];
        finalV   = (workQ[WIDTH-1] == opBQ[WIDTH-1]) &&
                   (addFull[WIDTH-1] != workQ[WIDTH-1]);
      end
      OP_SUB: begin
        finalRes = subRes;
        finalC   = (workQ >= opBQ);
        finalV   = (workQ[WIDTH-1] != opBQ[WIDTH-1]) &&
                   (subRes[WIDTH-1] != workQ[WIDTH-1]);
      end
      OP_AND: finalRes = workQ & opBQ;
      OP_OR:  finalRes = workQ | opBQ;
      OP_XOR: finalRes = workQ ^ opBQ;
      default: begin
        if (noShiftQ) begin
          finalRes = workQ;
          finalC   = 1'b0;
        end else begin
          finalRes = stepVal;
          finalC   = stepOut;
        end
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      stateQ <= ST_IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  // FSM next-state logic: a start in RUN is simply not looked at.
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      ST_IDLE: if (i_ctrlAluStart) stateD = ST_RUN;
      ST_RUN:  if (cntQ == SH_W'(1)) stateD = ST_IDLE;
      default: stateD = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    o_aluBusy = (stateQ == ST_RUN);
    o_aluDone = doneQ;
  end

  // ALU datapath next-state: capture in IDLE, count down and shift in RUN,
  // commit result and flags on the edge where the count expires.
  always_comb begin
    workD    = workQ;
    opBD     = opBQ;
    opD      = opQ;
    cntD     = cntQ;
    noShiftD = noShiftQ;
    resultD  = resultQ;
    flagND   = flagNQ;
    flagZD   = flagZQ;
    flagCD   = flagCQ;
    flagVD   = flagVQ;
    doneD    = 1'b0;
    case (stateQ)
      ST_IDLE: begin
        if (i_ctrlAluStart) begin
          workD = capA;
          opBD  = capB;
          opD   = aluOpT'(i_ctrlAluOp);
          if (startIsShift) begin
            cntD     = (capAmt == '0) ? SH_W'(1) : capAmt;
            noShiftD = (capAmt == '0);
          end else begin
            cntD     = SH_W'(1);
            noShiftD = 1'b0;
          end
        end
      end
      ST_RUN: begin
        cntD = cntQ - SH_W'(1);
        if (opIsShift && !noShiftQ) begin
          workD = stepVal;
        end
        if (cntQ == SH_W'(1)) begin
          resultD = finalRes;
          flagND  = finalRes[WIDTH-1];
          flagZD  = (finalRes == '0);
          flagCD  = finalC;
          flagVD  = finalV;
          doneD   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ALU datapath registers; reset discards any operation in flight.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      workQ    <= '0;
      opBQ     <= '0;
      opQ      <= OP_ADD;
      cntQ     <= '0;
      noShiftQ <= 1'b0;
      resultQ  <= '0;
      flagNQ   <= 1'b0;
      flagZQ   <= 1'b0;
      flagCQ   <= 1'b0;
      flagVQ   <= 1'b0;
      doneQ    <= 1'b0;
    end else begin
      workQ    <= workD;
      opBQ     <= opBD;
      opQ      <= opD;
      cntQ     <= cntD;
      noShiftQ <= noShiftD;
      resultQ  <= resultD;
      flagNQ   <= flagND;
      flagZQ   <= flagZD;
      flagCQ   <= flagCD;
      flagVQ   <= flagVD;
      doneQ    <= doneD;
    end
  end

  always_comb begin
    o_aluResult = resultQ;
    o_aluFlagN  = flagNQ;
    o_aluFlagZ  = flagZQ;
    o_aluFlagC  = flagCQ;
    o_aluFlagV  = flagVQ;
  end

endmodule

// File: tb/tb_datapath_multi.sv
// tb_datapath_multi
// -----------------------------------------------------------------------------
// Directed bench for datapath_multi (WIDTH=8, REG_COUNT=4). Each ALU start
// pushes its expected result, flags {N,Z,C,V} and latency onto a scoreboard
// queue; the entry is popped and compared when the done pulse appears.
// -----------------------------------------------------------------------------
module tb_datapath_multi;

  logic       clk;
  logic       reset;
  logic [7:0] busIn;
  logic       busInEn;
  logic       regBusEn;
  logic [1:0] regBusSel;
  logic       aluOE;
  logic       regWrEn;
  logic [1:0] regWrSel;
  logic [1:0] aluSelA;
  logic [1:0] aluSelB;
  logic [2:0] aluOp;
  logic       aluStart;
  logic [7:0] bus;
  logic       busConflict;
  logic [7:0] aluResult;
  logic       aluBusy;
  logic       aluDone;
  logic       flagN, flagZ, flagC, flagV;

  datapath_multi #(.WIDTH(8), .REG_COUNT(4)) dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_busIn         (busIn),
    .i_busInEn       (busInEn),
    .i_ctrlRegBusEn  (regBusEn),
    .i_ctrlRegBusSel (regBusSel),
    .i_ctrlAluOE     (aluOE),
    .i_ctrlRegWrEn   (regWrEn),
    .i_ctrlRegWrSel  (regWrSel),
    .i_ctrlAluSelA   (aluSelA),
    .i_ctrlAluSelB   (aluSelB),
    .i_ctrlAluOp     (aluOp),
    .i_ctrlAluStart  (aluStart),
    .o_bus           (bus),
    .o_busConflict   (busConflict),
    .o_aluResult     (aluResult),
    .o_aluBusy       (aluBusy),
    .o_aluDone       (aluDone),
    .o_aluFlagN      (flagN),
    .o_aluFlagZ      (flagZ),
    .o_aluFlagC      (flagC),
    .o_aluFlagV      (flagV)
  );

  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, AND_ = 3'd2, OR_ = 3'd3,
                         XOR_ = 3'd4, SHL = 3'd5, SHR = 3'd6, ASR = 3'd7;

  typedef struct {
    logic [7:0] result;
    logic [3:0] flags;
    int         latency;
  } expT;

  expT sbQ[$];
  int  checks = 0;
  int  errors = 0;
  int  cycleCount = 0;
  int  t0 = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running edge counter used to measure ALU latency
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Single comparison point: counts it and reports any difference
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Return every control input to its inactive value
  task automatic applyStimulus();
    busInEn  = 1'b0;
    regBusEn = 1'b0;
    aluOE    = 1'b0;
    regWrEn  = 1'b0;
    aluStart = 1'b0;
  endtask

  task automatic writeReg(input logic [1:0] r, input logic [7:0] v);
    busIn    = v;
    busInEn  = 1'b1;
    regWrEn  = 1'b1;
    regWrSel = r;
    @(negedge clk);
    applyStimulus();
  endtask

  task automatic readReg(input string tag, input logic [1:0] r,
                         input logic [7:0] exp);
    regBusEn  = 1'b1;
    regBusSel = r;
    #1;
    checkOutput(tag, bus, exp);
    regBusEn = 1'b0;
  endtask

  // Drive a start (on top of whatever else the caller set up) for one edge
  task automatic issueStart(input logic [2:0] op, input logic [1:0] a,
                            input logic [1:0] b);
    aluOp    = op;
    aluSelA  = a;
    aluSelB  = b;
    aluStart = 1'b1;
    @(negedge clk);
    t0 = cycleCount;
    applyStimulus();
  endtask

  task automatic startOp(input logic [2:0] op, input logic [1:0] a,
                         input logic [1:0] b, input logic [7:0] expRes,
                         input logic [3:0] expFlags, input int expLat);
    expT e;
    e.result  = expRes;
    e.flags   = expFlags;
    e.latency = expLat;
    sbQ.push_back(e);
    issueStart(op, a, b);
  endtask

  // Wait (bounded) for completion, then pop the scoreboard and compare
  task automatic waitDone(input string tag);
    int  guard;
    expT e;
    guard = 0;
    while (aluBusy === 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    checkOutput({tag, " done"}, aluDone, 1);
    checkOutput({tag, " busy"}, aluBusy, 0);
    if (sbQ.size() == 0) begin
      checkOutput({tag, " scoreboard entry"}, 0, 1);
    end else begin
      e = sbQ.pop_front();
      checkOutput({tag, " result"}, aluResult, e.result);
      checkOutput({tag, " flags"}, {flagN, flagZ, flagC, flagV}, e.flags);
      checkOutput({tag, " latency"}, cycleCount - t0, e.latency);
    end
  endtask

  // Count done pulses over a window; a single-cycle pulse leaves none behind
  task automatic checkNoDone(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (aluDone === 1'b1) seen++;
    end
    checkOutput(tag, seen, 0);
  endtask

  initial begin
    reset     = 1'b1;
    busIn     = '0;
    regBusSel = '0;
    regWrSel  = '0;
    aluSelA   = '0;
    aluSelB   = '0;
    aluOp     = '0;
    applyStimulus();
    @(negedge clk);
    checkOutput("reset result", aluResult, 0);
    checkOutput("reset flags", {flagN, flagZ, flagC, flagV}, 0);
    checkOutput("reset busy", aluBusy, 0);
    checkOutput("reset done", aluDone, 0);
    checkOutput("reset idle bus", bus, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Register writes and ADD
    writeReg(2'd0, 8'h2A);
    writeReg(2'd1, 8'h15);
    readReg("r0 readback", 2'd0, 8'h2A);
    readReg("r1 readback", 2'd1, 8'h15);
    startOp(ADD, 2'd0, 2'd1, 8'h3F, 4'b0000, 1);
    waitDone("add 2A+15");
    aluOE = 1'b1;
    #1;
    checkOutput("alu on bus", bus, 8'h3F);
    checkOutput("alu on bus conflict", busConflict, 0);
    aluOE = 1'b0;
    checkNoDone("add single pulse", 3);

    // Subtraction
    startOp(SUB, 2'd1, 2'd0, 8'hEB, 4'b1000, 1);
    waitDone("sub 15-2A");
    startOp(SUB, 2'd0, 2'd0, 8'h00, 4'b0110, 1);
    waitDone("sub r0-r0");
    writeReg(2'd2, 8'h80);
    writeReg(2'd3, 8'h01);
    startOp(SUB, 2'd2, 2'd3, 8'h7F, 4'b0011, 1);
    waitDone("sub 80-01");

    // Addition overflow and carry
    writeReg(2'd2, 8'h7F);
    startOp(ADD, 2'd2, 2'd3, 8'h80, 4'b1001, 1);
    waitDone("add 7F+01");
    writeReg(2'd2, 8'hFF);
    startOp(ADD, 2'd2, 2'd3, 8'h00, 4'b0110, 1);
    waitDone("add FF+01");

    // Shifts
    writeReg(2'd2, 8'h81);
    writeReg(2'd3, 8'h03);
    startOp(SHL, 2'd2, 2'd3, 8'h08, 4'b0000, 3);
    waitDone("shl 81 by 3");
    writeReg(2'd2, 8'h80);
    writeReg(2'd3, 8'h02);
    startOp(ASR, 2'd2, 2'd3, 8'hE0, 4'b1000, 2);
    waitDone("asr 80 by 2");
    writeReg(2'd2, 8'h01);
    writeReg(2'd3, 8'h01);
    startOp(SHR, 2'd2, 2'd3, 8'h00, 4'b0110, 1);
    waitDone("shr 01 by 1");
    writeReg(2'd2, 8'h81);
    writeReg(2'd3, 8'h00);
    startOp(SHL, 2'd2, 2'd3, 8'h81, 4'b1000, 1);
    waitDone("shl by 0");
    writeReg(2'd3, 8'h08);
    startOp(ASR, 2'd2, 2'd3, 8'h81, 4'b1000, 1);
    waitDone("asr by 8 wraps to 0");

    // Logic ops issued back-to-back, each start in the previous done cycle
    startOp(AND_, 2'd0, 2'd1, 8'h00, 4'b0100, 1);
    waitDone("and 2A&15");
    startOp(OR_, 2'd0, 2'd1, 8'h3F, 4'b0000, 1);
    waitDone("or 2A|15");
    startOp(XOR_, 2'd0, 2'd2, 8'hAB, 4'b1000, 1);
    waitDone("xor 2A^81");
    checkNoDone("logic single pulse", 3);

    // A write on the start edge is not seen by the captured operand
    busIn    = 8'h01;
    busInEn  = 1'b1;
    regWrEn  = 1'b1;
    regWrSel = 2'd0;
    startOp(ADD, 2'd0, 2'd1, 8'h3F, 4'b0000, 1);
    waitDone("same-edge write");
    readReg("r0 after same-edge write", 2'd0, 8'h01);

    // Start while busy is ignored; a write during the run is allowed
    writeReg(2'd2, 8'h0B);
    writeReg(2'd3, 8'h05);
    startOp(SHL, 2'd2, 2'd3, 8'h60, 4'b0010, 5);
    busIn    = 8'hFF;
    busInEn  = 1'b1;
    regWrEn  = 1'b1;
    regWrSel = 2'd2;
    aluOp    = ADD;
    aluSelA  = 2'd0;
    aluSelB  = 2'd1;
    aluStart = 1'b1;
    @(negedge clk);
    applyStimulus();
    waitDone("shl 0B by 5 with ignored start");
    checkNoDone("ignored start gives no second done", 8);
    checkOutput("result held", aluResult, 8'h60);
    readReg("r2 written while busy", 2'd2, 8'hFF);

    // Bus contention and priority
    busIn     = 8'h55;
    busInEn   = 1'b1;
    aluOE     = 1'b1;
    regBusEn  = 1'b1;
    regBusSel = 2'd2;
    #1;
    checkOutput("all enables bus", bus, 8'h55);
    checkOutput("all enables conflict", busConflict, 1);
    busInEn = 1'b0;
    #1;
    checkOutput("alu+reg bus", bus, 8'h60);
    checkOutput("alu+reg conflict", busConflict, 1);
    aluOE   = 1'b0;
    busInEn = 1'b1;
    #1;
    checkOutput("in+reg bus", bus, 8'h55);
    checkOutput("in+reg conflict", busConflict, 1);
    busInEn = 1'b0;
    #1;
    checkOutput("reg only bus", bus, 8'hFF);
    checkOutput("reg only conflict", busConflict, 0);
    regBusEn = 1'b0;
    #1;
    checkOutput("no enables bus", bus, 0);
    checkOutput("no enables conflict", busConflict, 0);
    @(negedge clk);

    // Reset in cycle 2 of a SHL by 7 discards the operation
    writeReg(2'd2, 8'h01);
    writeReg(2'd3, 8'h07);
    issueStart(SHL, 2'd2, 2'd3);
    checkOutput("shl 7 busy cycle 1", aluBusy, 1);
    @(negedge clk);
    checkOutput("shl 7 busy cycle 2", aluBusy, 1);
    reset = 1'b1;
    #1;
    checkOutput("mid-op reset busy", aluBusy, 0);
    checkOutput("mid-op reset result", aluResult, 0);
    checkOutput("mid-op reset flags", {flagN, flagZ, flagC, flagV}, 0);
    checkOutput("mid-op reset done", aluDone, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int r = 0; r < 4; r++) begin
      readReg($sformatf("reg %0d after reset", r), 2'(r), 8'h00);
    end
    checkNoDone("no done after reset", 12);
    checkOutput("busy stays low after reset", aluBusy, 0);
    checkOutput("scoreboard drained", sbQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
